// File: rtl/mem_arbiter_if.sv
// Bundle of every non-clock, non-reset signal of mem_arbiter: both requester
// ports (I and D) and the shared 256-bit memory port, plus the watchdog flag.
// Modport slave is the arbiter's view; modport master is the surrounding logic's view.
interface mem_arbiter_if;
    // instruction-cache side
    logic         i_req_i;
    logic         i_write_i;
    logic [31:0]  i_addr_i;
    logic [255:0] i_data_i;
    logic         i_ack_o;
    logic [255:0] i_data_o;
    // data-cache side
    logic         d_req_i;
    logic         d_write_i;
    logic [31:0]  d_addr_i;
    logic [255:0] d_data_i;
    logic         d_ack_o;
    logic [255:0] d_data_o;
    // memory side
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    // sticky watchdog flag
    logic         err_timeout_o;

    modport slave (
        input  i_req_i, i_write_i, i_addr_i, i_data_i,
        input  d_req_i, d_write_i, d_addr_i, d_data_i,
        input  mem_data_i, mem_ack_i,
        output i_ack_o, i_data_o, d_ack_o, d_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output err_timeout_o
    );

    modport master (
        output i_req_i, i_write_i, i_addr_i, i_data_i,
        output d_req_i, d_write_i, d_addr_i, d_data_i,
        output mem_data_i, mem_ack_i,
        input  i_ack_o, i_data_o, d_ack_o, d_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  err_timeout_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one 256-bit memory port between the I-cache (I) and D-cache (D) controllers,
//          one transaction outstanding, grant held until mem_ack_i or watchdog abort.
// Latency: request seen at edge N -> mem_enable_o high in cycle N+1; ack returned combinationally
//          in the mem_ack_i cycle; one forced IDLE cycle between transactions.
// Backpressure: requesters hold req until their ack; the losing requester simply waits.
// Ports: clk_i (rising edge), rst_i (async, active low), bus (mem_arbiter_if.slave: I/D request
//        ports, memory port, err_timeout_o).
module mem_arbiter #(
    parameter bit          RR_EN       = 1'b1,  // 1: round-robin on ties, 0: D always wins ties
    parameter int unsigned TIMEOUT_CYC = 1023,  // BUSY cycles without ack before abort, 0 = off
    parameter int          TO_W        = 10     // watchdog counter width, must hold TIMEOUT_CYC
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    localparam bit              WD_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] WD_LAST = WD_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

    state_t          state;
    state_t          state_nxt;
    logic            last_grant_d;  // 1 = D held the most recent grant
    logic [TO_W-1:0] wd_cnt;
    logic            err_timeout;
    logic            wd_fire;
    logic            busy_i;
    logic            busy_d;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        wd_fire   = 1'b0;
        case (state)
            IDLE: begin
                // Acks arriving here are stale (after reset/abort) and are dropped.
                if (bus.i_req_i && bus.d_req_i) begin
                    // Round-robin picks whoever was not granted last.
                    state_nxt = (RR_EN && last_grant_d) ? BUSY_I : BUSY_D;
                end else if (bus.d_req_i) begin
                    state_nxt = BUSY_D;
                end else if (bus.i_req_i) begin
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // Ack beats the watchdog when both land in the same cycle.
                // A requester dropping req mid-transaction does not release the grant.
                if (bus.mem_ack_i) begin
                    state_nxt = IDLE;
                end else if (WD_EN && (wd_cnt == WD_LAST)) begin
                    state_nxt = IDLE;
                    wd_fire   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- grant history, watchdog, error flag ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant_d <= 1'b1;
            wd_cnt       <= '0;
            err_timeout  <= 1'b0;
        end else begin
            if ((state == IDLE) && (state_nxt != IDLE)) begin
                last_grant_d <= (state_nxt == BUSY_D);
            end
            // Every BUSY window is entered from IDLE, so holding the counter
            // at zero in IDLE is the same as clearing it on BUSY entry.
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // ---------------- memory-side mux ----------------
    assign busy_i = (state == BUSY_I);
    assign busy_d = (state == BUSY_D);

    assign bus.mem_enable_o = busy_i | busy_d;
    assign bus.mem_write_o  = (busy_i & bus.i_write_i) | (busy_d & bus.d_write_i);
    assign bus.mem_addr_o   = busy_i ? bus.i_addr_i : (busy_d ? bus.d_addr_i : 32'h0);
    assign bus.mem_data_o   = busy_i ? bus.i_data_i : (busy_d ? bus.d_data_i : 256'h0);

    // ---------------- requester-side return ----------------
    // Read data is broadcast; only the granted side ever sees an ack.
    assign bus.i_ack_o       = busy_i & bus.mem_ack_i;
    assign bus.d_ack_o       = busy_d & bus.mem_ack_i;
    assign bus.i_data_o      = bus.mem_data_i;
    assign bus.d_data_o      = bus.mem_data_i;
    assign bus.err_timeout_o = err_timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances share one stimulus set.
//   u_a: round-robin, watchdog effectively off (1023)
//   u_b: fixed priority, watchdog 8
//   u_c: round-robin, watchdog 4
module tb_mem_arbiter;

    localparam logic [31:0] IA = 32'h0000_0100;
    localparam logic [31:0] DA = 32'h0000_0200;
    localparam logic [31:0] Z  = 32'h0;

    logic         clk;
    logic         rst;
    logic         i_req, i_write, d_req, d_write, mem_ack;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] i_data, d_data, mem_data;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter_if if_a ();
    mem_arbiter_if if_b ();
    mem_arbiter_if if_c ();

    assign if_a.i_req_i = i_req;    assign if_b.i_req_i = i_req;    assign if_c.i_req_i = i_req;
    assign if_a.i_write_i = i_write; assign if_b.i_write_i = i_write; assign if_c.i_write_i = i_write;
    assign if_a.i_addr_i = i_addr;  assign if_b.i_addr_i = i_addr;  assign if_c.i_addr_i = i_addr;
    assign if_a.i_data_i = i_data;  assign if_b.i_data_i = i_data;  assign if_c.i_data_i = i_data;
    assign if_a.d_req_i = d_req;    assign if_b.d_req_i = d_req;    assign if_c.d_req_i = d_req;
    assign if_a.d_write_i = d_write; assign if_b.d_write_i = d_write; assign if_c.d_write_i = d_write;
    assign if_a.d_addr_i = d_addr;  assign if_b.d_addr_i = d_addr;  assign if_c.d_addr_i = d_addr;
    assign if_a.d_data_i = d_data;  assign if_b.d_data_i = d_data;  assign if_c.d_data_i = d_data;
    assign if_a.mem_data_i = mem_data; assign if_b.mem_data_i = mem_data; assign if_c.mem_data_i = mem_data;
    assign if_a.mem_ack_i = mem_ack; assign if_b.mem_ack_i = mem_ack; assign if_c.mem_ack_i = mem_ack;

    mem_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYC(1023), .TO_W(10)) u_a (.clk_i(clk), .rst_i(rst), .bus(if_a.slave));
    mem_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYC(8),    .TO_W(4))  u_b (.clk_i(clk), .rst_i(rst), .bus(if_b.slave));
    mem_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYC(4),    .TO_W(3))  u_c (.clk_i(clk), .rst_i(rst), .bus(if_c.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 256'(act), 256'(exp));
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, 256'(act), 256'(exp));
    endtask

    // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
    task automatic step(input logic ir, input logic dr, input logic ak);
        @(negedge clk);
        i_req   = ir;
        d_req   = dr;
        mem_ack = ak;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One row per cycle of the arbitration sequence: inputs, then expected outputs
    // of the round-robin instance (rr) and the fixed-priority instance (fp).
    typedef struct packed {
        logic        i_req;
        logic        d_req;
        logic        ack;
        logic        en;
        logic [31:0] addr_rr;
        logic        i_ack_rr;
        logic        d_ack_rr;
        logic [31:0] addr_fp;
        logic        i_ack_fp;
        logic        d_ack_fp;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [255:0] wdat_for(input logic [31:0] addr);
        if (addr == IA) return i_data;
        if (addr == DA) return d_data;
        return 256'h0;
    endfunction

    initial begin
        //            ir    dr    ak    en    rr addr,ia,  da    fp addr,ia,  da
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,  1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, IA, 1'b0, 1'b0, DA, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, IA, 1'b1, 1'b0, DA, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,  1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, DA, 1'b0, 1'b1, DA, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,  1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, IA, 1'b1, 1'b0, DA, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,  1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, DA, 1'b0, 1'b1, DA, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, Z,  1'b0, 1'b0, Z,  1'b0, 1'b0};  // stale ack in IDLE
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, IA, 1'b1, 1'b0, DA, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,  1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, DA, 1'b0, 1'b1, DA, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,  1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, IA, 1'b1, 1'b0, IA, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,  1'b0, 1'b0};

        rst = 1'b1;
        i_req = 1'b0; i_write = 1'b0; i_addr = 32'h0; i_data = 256'h0;
        d_req = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_data = 256'h0;
        mem_ack = 1'b0; mem_data = 256'h0;

        // ---- reset state: outputs quiet even with requests and an ack pending ----
        #1 rst = 1'b0;
        i_req = 1'b1; d_req = 1'b1; mem_ack = 1'b1; i_write = 1'b1; d_write = 1'b1;
        i_addr = 32'h44; d_addr = 32'h88;
        #2;
        chk1("rst_a_en",   if_a.mem_enable_o, 1'b0);
        chk1("rst_a_wr",   if_a.mem_write_o,  1'b0);
        chk32("rst_a_addr", if_a.mem_addr_o,  Z);
        chk1("rst_a_iack", if_a.i_ack_o,      1'b0);
        chk1("rst_a_dack", if_a.d_ack_o,      1'b0);
        chk1("rst_b_err",  if_b.err_timeout_o, 1'b0);
        chk1("rst_c_err",  if_c.err_timeout_o, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk1("rst_hold_a_en", if_a.mem_enable_o, 1'b0);
        chk1("rst_hold_b_en", if_b.mem_enable_o, 1'b0);
        do_reset();

        // ---- T2: arbitration sequence, RR vs fixed priority ----
        i_addr = IA; d_addr = DA; i_write = 1'b0; d_write = 1'b1;
        i_data = 256'h1111; d_data = 256'h2222; mem_data = 256'hC0FFEE;
        for (int k = 0; k < 16; k++) begin
            step(tbl[k].i_req, tbl[k].d_req, tbl[k].ack);
            chk1($sformatf("t2[%0d]_a_en", k),    if_a.mem_enable_o, tbl[k].en);
            chk32($sformatf("t2[%0d]_a_addr", k), if_a.mem_addr_o,   tbl[k].addr_rr);
            chk1($sformatf("t2[%0d]_a_wr", k),    if_a.mem_write_o,  tbl[k].addr_rr == DA);
            chk($sformatf("t2[%0d]_a_wdat", k),   if_a.mem_data_o,   wdat_for(tbl[k].addr_rr));
            chk1($sformatf("t2[%0d]_a_iack", k),  if_a.i_ack_o,      tbl[k].i_ack_rr);
            chk1($sformatf("t2[%0d]_a_dack", k),  if_a.d_ack_o,      tbl[k].d_ack_rr);
            chk($sformatf("t2[%0d]_a_idat", k),   if_a.i_data_o,     256'hC0FFEE);
            chk1($sformatf("t2[%0d]_b_en", k),    if_b.mem_enable_o, tbl[k].en);
            chk32($sformatf("t2[%0d]_b_addr", k), if_b.mem_addr_o,   tbl[k].addr_fp);
            chk1($sformatf("t2[%0d]_b_iack", k),  if_b.i_ack_o,      tbl[k].i_ack_fp);
            chk1($sformatf("t2[%0d]_b_dack", k),  if_b.d_ack_o,      tbl[k].d_ack_fp);
        end

        // ---- T1: single D read, memory acks in the 10th BUSY cycle ----
        do_reset();
        d_addr = 32'h400; d_write = 1'b0; mem_data = 256'h0;
        step(1'b0, 1'b1, 1'b0);
        chk1("t1_idle_en", if_a.mem_enable_o, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) mem_data = {32{8'hA5}};
            step(1'b0, 1'b1, c == 10);
            chk1($sformatf("t1_c%0d_en", c),    if_a.mem_enable_o, 1'b1);
            chk32($sformatf("t1_c%0d_addr", c), if_a.mem_addr_o,   32'h400);
            chk1($sformatf("t1_c%0d_wr", c),    if_a.mem_write_o,  1'b0);
            chk1($sformatf("t1_c%0d_iack", c),  if_a.i_ack_o,      1'b0);
            chk1($sformatf("t1_c%0d_dack", c),  if_a.d_ack_o,      c == 10);
        end
        chk("t1_ddata", if_a.d_data_o, {32{8'hA5}});
        step(1'b0, 1'b0, 1'b0);
        chk1("t1_after_en",   if_a.mem_enable_o, 1'b0);
        chk1("t1_after_dack", if_a.d_ack_o,      1'b0);

        // ---- T3: I-side write pass-through ----
        do_reset();
        i_addr = 32'h20; i_write = 1'b1; i_data = 256'h1234;
        step(1'b1, 1'b0, 1'b0);
        chk("t3_idle_wdat", if_a.mem_data_o, 256'h0);
        for (int c = 1; c <= 3; c++) begin
            step(1'b1, 1'b0, c == 3);
            chk1($sformatf("t3_c%0d_en", c),    if_a.mem_enable_o, 1'b1);
            chk1($sformatf("t3_c%0d_wr", c),    if_a.mem_write_o,  1'b1);
            chk32($sformatf("t3_c%0d_addr", c), if_a.mem_addr_o,   32'h20);
            chk($sformatf("t3_c%0d_wdat", c),   if_a.mem_data_o,   256'h1234);
            chk1($sformatf("t3_c%0d_iack", c),  if_a.i_ack_o,      c == 3);
            chk1($sformatf("t3_c%0d_dack", c),  if_a.d_ack_o,      1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk1("t3_after_en", if_a.mem_enable_o, 1'b0);
        chk1("t3_after_wr", if_a.mem_write_o,  1'b0);

        // ---- T4: watchdog abort at 8 BUSY cycles (u_b) ----
        do_reset();
        d_addr = 32'h400; d_write = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk1("t4_idle_en", if_b.mem_enable_o, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, 1'b1, 1'b0);
            chk1($sformatf("t4_c%0d_en", c),   if_b.mem_enable_o,  1'b1);
            chk1($sformatf("t4_c%0d_err", c),  if_b.err_timeout_o, 1'b0);
            chk1($sformatf("t4_c%0d_dack", c), if_b.d_ack_o,       1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk1("t4_abort_en",  if_b.mem_enable_o,  1'b0);
        chk1("t4_abort_err", if_b.err_timeout_o, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk1("t4_stale_dack", if_b.d_ack_o,       1'b0);
        chk1("t4_stale_iack", if_b.i_ack_o,       1'b0);
        chk1("t4_stale_en",   if_b.mem_enable_o,  1'b0);
        chk1("t4_stale_err",  if_b.err_timeout_o, 1'b1);
        i_addr = 32'h20; i_write = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk1("t4_new_idle_en", if_b.mem_enable_o, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk1("t4_new_en",    if_b.mem_enable_o,  1'b1);
        chk32("t4_new_addr", if_b.mem_addr_o,    32'h20);
        chk1("t4_new_iack",  if_b.i_ack_o,       1'b1);
        chk1("t4_new_err",   if_b.err_timeout_o, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk1("t4_end_en",  if_b.mem_enable_o,  1'b0);
        chk1("t4_end_err", if_b.err_timeout_o, 1'b1);

        // ---- T5: asynchronous reset during BUSY_D (u_a) ----
        do_reset();
        d_addr = 32'h400;
        step(1'b0, 1'b1, 1'b0);
        chk1("t5_idle_en", if_a.mem_enable_o, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk1("t5_busy_en", if_a.mem_enable_o, 1'b1);
        #1;
        rst = 1'b0;
        d_req = 1'b0;
        #1;
        chk1("t5_async_en",   if_a.mem_enable_o, 1'b0);
        chk32("t5_async_addr", if_a.mem_addr_o,  Z);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk1("t5_post_en", if_a.mem_enable_o, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk1("t5_stale_dack", if_a.d_ack_o,      1'b0);
        chk1("t5_stale_iack", if_a.i_ack_o,      1'b0);
        chk1("t5_stale_en",   if_a.mem_enable_o, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk1("t5_rereq_idle_en", if_a.mem_enable_o, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk1("t5_rereq_en",   if_a.mem_enable_o, 1'b1);
        chk1("t5_rereq_dack", if_a.d_ack_o,      1'b1);
        step(1'b0, 1'b0, 1'b0);

        // ---- T6: ack on the watchdog-limit cycle wins (u_c, limit 4) ----
        do_reset();
        d_addr = 32'h400; mem_data = 256'hBEEF;
        step(1'b0, 1'b1, 1'b0);
        chk1("t6_idle_en", if_c.mem_enable_o, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b1, c == 4);
            chk1($sformatf("t6_c%0d_en", c),   if_c.mem_enable_o,  1'b1);
            chk1($sformatf("t6_c%0d_dack", c), if_c.d_ack_o,       c == 4);
            chk1($sformatf("t6_c%0d_err", c),  if_c.err_timeout_o, 1'b0);
        end
        chk("t6_ddata", if_c.d_data_o, 256'hBEEF);
        step(1'b0, 1'b0, 1'b0);
        chk1("t6_after_en",  if_c.mem_enable_o,  1'b0);
        chk1("t6_after_err", if_c.err_timeout_o, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk1("t6_late_err", if_c.err_timeout_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
